// File: rtl/btn_scan_ctrl.sv
// btn_scan_ctrl: round-robin debouncer for N_BTN buttons feeding an event FIFO.
// Define BTN_RELEASE_EVT_EN to emit release events as well as press events.
module btn_scan_ctrl #(
    parameter int N_BTN      = 4,
    parameter int TICK_DIV   = 1000000,
    parameter int STABLE_CNT = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic [N_BTN-1:0]         btn_in,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_press,
    output logic [N_BTN-1:0]         btn_state,
    output logic                     overflow
);
    localparam int IW = $clog2(N_BTN);
    localparam int DW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;

    typedef enum logic [1:0] {IDLE, SAMPLE, COMMIT} state_t;

    state_t           state;
    logic [N_BTN-1:0] sync1, sync2;
    logic [DW-1:0]    div;
    logic [IW-1:0]    idx;
    logic             s, diff;
    logic [CW-1:0]    cnt [N_BTN];
    logic [IW:0]      mem [FIFO_DEPTH];
    logic [IW:0]      hold;
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [NW-1:0]    count;
    logic             tick, flip, push, pop, full, wr;

    assign tick      = div == DW'(TICK_DIV - 1);
    assign flip      = state == COMMIT && diff && cnt[idx] == CW'(STABLE_CNT - 1);
`ifdef BTN_RELEASE_EVT_EN
    assign push      = flip;
`else
    assign push      = flip && s;
`endif
    assign evt_valid = count != '0;
    assign full      = count == NW'(FIFO_DEPTH);
    assign pop       = evt_valid && evt_ready;
    assign wr        = push && (!full || pop);
    // Show-ahead head; when empty, keep presenting the last head seen.
    assign {evt_id, evt_press} = evt_valid ? mem[rd_ptr] : hold;

    always_ff @(posedge clk) begin
        if (res) begin
            sync1     <= '0;
            sync2     <= '0;
            div       <= '0;
            state     <= IDLE;
            idx       <= '0;
            s         <= 1'b0;
            diff      <= 1'b0;
            cnt       <= '{default: '0};
            btn_state <= '0;
            mem       <= '{default: '0};
            hold      <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            div   <= tick ? '0 : div + 1'b1;
            if (evt_valid)
                hold <= mem[rd_ptr];
            unique case (state)
                IDLE: if (tick) state <= SAMPLE;
                SAMPLE: begin
                    s     <= sync2[idx];
                    diff  <= sync2[idx] != btn_state[idx];
                    state <= COMMIT;
                end
                COMMIT: begin
                    if (!diff)
                        cnt[idx] <= '0;
                    else if (flip) begin
                        btn_state[idx] <= s;
                        cnt[idx]       <= '0;
                    end else
                        cnt[idx] <= cnt[idx] + 1'b1;
                    idx   <= (idx == IW'(N_BTN - 1)) ? '0 : idx + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (wr) begin
                mem[wr_ptr] <= {idx, s};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !wr)
                overflow <= 1'b1;
            count <= count + NW'(wr) - NW'(pop);
        end
    end
endmodule

// File: tb/tb_btn_scan_ctrl.sv
// tb_btn_scan_ctrl: directed and randomized checks of btn_scan_ctrl against a visit-level model.
module tb_btn_scan_ctrl;
    localparam int N = 4, TD = 4, SC = 3, FD = 2;
`ifdef BTN_RELEASE_EVT_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic       clk = 1'b0, res = 1'b1, evt_ready = 1'b0;
    logic [3:0] btn_in = '0;
    logic       evt_valid, evt_press, overflow;
    logic [1:0] evt_id;
    logic [3:0] btn_state;
    int checks = 0, errors = 0;

    btn_scan_ctrl #(.N_BTN(N), .TICK_DIV(TD), .STABLE_CNT(SC), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .res(res), .btn_in(btn_in), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_id(evt_id), .evt_press(evt_press), .btn_state(btn_state), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: edges counted from reset, scan tick every TD edges, one button per tick.
    int         m_e, m_vis, m_cnt [N];
    logic [3:0] m_h1, m_h2, m_st;
    logic       m_s, m_ovf;
    logic [2:0] m_q [$];

    always @(posedge clk) begin : model
        bit pop, push;
        int b;
        logic [2:0] ev;
        if (res) begin
            m_e = 0; m_vis = 0; m_h1 = '0; m_h2 = '0; m_st = '0; m_s = 1'b0; m_ovf = 1'b0;
            m_q.delete();
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else begin
            m_e++;
            pop = m_q.size() != 0 && evt_ready;
            push = 1'b0;
            ev = '0;
            if (m_e > 2 && m_e % TD == 2) begin
                b = m_vis % N;
                if (m_s == m_st[b]) m_cnt[b] = 0;
                else if (m_cnt[b] == SC - 1) begin
                    m_st[b] = m_s;
                    m_cnt[b] = 0;
                    push = REL || m_s;
                    ev = {2'(b), m_s};
                end else m_cnt[b]++;
                m_vis++;
            end
            if (m_e > 1 && m_e % TD == 1) m_s = m_h2[m_vis % N];
            m_h2 = m_h1;
            m_h1 = btn_in;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < FD) m_q.push_back(ev);
                else m_ovf = 1'b1;
            end
        end
    end

    task automatic do_reset();
        res = 1'b1;
        repeat (2) @(negedge clk);
        res = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1; btn_in = 4'hF; evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({evt_valid, evt_id, evt_press, btn_state, overflow} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 000000000", {evt_valid, evt_id, evt_press, btn_state, overflow});
        end
        res = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (btn_state !== 4'b0) begin
            errors++;
            $display("FAIL reset_no_early_flip: btn_state got %b required 0000", btn_state);
        end
    endtask

    task automatic test_press();
        bit found = 0;
        int at = 0, bad = 0;
        do_reset();
        btn_in = 4'b0100; evt_ready = 1'b0;
        for (int i = 1; i <= 60 && !found; i++) begin
            @(negedge clk);
            if (evt_valid) begin found = 1; at = i; end
        end
        checks++;
        if (!found || at != 46) begin
            errors++;
            $display("FAIL press_latency: got cycle %0d (found=%0d) required 46", at, found);
        end
        checks++;
        if ({evt_valid, evt_id, evt_press, btn_state} !== 8'b1_10_1_0100) begin
            errors++;
            $display("FAIL press_event: got %b required 11010100", {evt_valid, evt_id, evt_press, btn_state});
        end
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (evt_valid || btn_state !== 4'b0100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL press_hold_quiet: got %0d bad cycles required 0", bad);
        end
    endtask

    task automatic test_glitch();
        int evts = 0;
        do_reset();
        btn_in = 4'b0010; evt_ready = 1'b1;
        for (int i = 1; i <= 110; i++) begin
            @(negedge clk);
            if (evt_valid) evts++;
            btn_in = ((i >= 30 && i < 49) || i >= 85) ? 4'b0000 : 4'b0010;
        end
        checks++;
        if (evts != 0) begin
            errors++;
            $display("FAIL glitch_events: got %0d required 0", evts);
        end
        checks++;
        if (btn_state !== 4'b0000) begin
            errors++;
            $display("FAIL glitch_state: got %b required 0000", btn_state);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        btn_in = 4'b1011; evt_ready = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (i == 45) begin
                checks++;
                if ({evt_valid, overflow} !== 2'b10) begin
                    errors++;
                    $display("FAIL bp_before_drop: valid,overflow got %b required 10", {evt_valid, overflow});
                end
            end
        end
        checks++;
        if ({evt_valid, evt_id, evt_press, overflow, btn_state} !== 9'b1_00_1_1_1011) begin
            errors++;
            $display("FAIL bp_full: got %b required 100111011", {evt_valid, evt_id, evt_press, overflow, btn_state});
        end
        evt_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({evt_valid, evt_id, evt_press} !== 4'b1_01_1) begin
            errors++;
            $display("FAIL bp_drain_second: got %b required 1011", {evt_valid, evt_id, evt_press});
        end
        @(negedge clk);
        checks++;
        if ({evt_valid, overflow} !== 2'b01) begin
            errors++;
            $display("FAIL bp_drained: valid,overflow got %b required 01", {evt_valid, overflow});
        end
    endtask

    task automatic test_release();
        int n = 0;
        logic [2:0] ev = '0;
        do_reset();
        btn_in = 4'b0100; evt_ready = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (btn_state !== 4'b0100) begin
            errors++;
            $display("FAIL release_setup: btn_state got %b required 0100", btn_state);
        end
        btn_in = 4'b0000;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (evt_valid) begin n++; ev = {evt_id, evt_press}; end
        end
        checks++;
        if (n != (REL ? 1 : 0)) begin
            errors++;
            $display("FAIL release_count: got %0d required %0d", n, REL ? 1 : 0);
        end
        if (n != 0) begin
            checks++;
            if (ev !== 3'b100) begin
                errors++;
                $display("FAIL release_event: got %b required 100", ev);
            end
        end
        checks++;
        if (btn_state !== 4'b0000) begin
            errors++;
            $display("FAIL release_state: got %b required 0000", btn_state);
        end
    endtask

    task automatic test_midreset();
        bit found = 0;
        int at = 0;
        do_reset();
        btn_in = 4'b0011; evt_ready = 1'b0;
        for (int i = 1; i <= 60 && !found; i++) begin
            @(negedge clk);
            found = evt_valid;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_setup: evt_valid got 0 required 1");
        end
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        checks++;
        if ({evt_valid, overflow, btn_state} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_clear: got %b required 000000", {evt_valid, overflow, btn_state});
        end
        evt_ready = 1'b1;
        found = 0;
        for (int i = 1; i <= 60 && !found; i++) begin
            @(negedge clk);
            if (evt_valid) begin found = 1; at = i; end
        end
        checks++;
        if (!found || at != 38 || {evt_id, evt_press} !== 3'b001) begin
            errors++;
            $display("FAIL midreset_restart: got cycle %0d id %0d press %b required cycle 38 id 0 press 1", at, evt_id, evt_press);
        end
    endtask

    task automatic test_random();
        do_reset();
        btn_in = '0; evt_ready = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            checks++;
            if (evt_valid !== (m_q.size() != 0)) begin
                errors++;
                $display("FAIL rand_valid @%0d: got %b required %b", i, evt_valid, m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                checks++;
                if ({evt_id, evt_press} !== m_q[0]) begin
                    errors++;
                    $display("FAIL rand_head @%0d: got %b required %b", i, {evt_id, evt_press}, m_q[0]);
                end
            end
            checks++;
            if (btn_state !== m_st) begin
                errors++;
                $display("FAIL rand_state @%0d: got %b required %b", i, btn_state, m_st);
            end
            checks++;
            if (overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand_overflow @%0d: got %b required %b", i, overflow, m_ovf);
            end
            if ($urandom_range(0, 29) == 0) btn_in[$urandom_range(0, 3)] ^= 1'b1;
            evt_ready = ((i / 500) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            res = $urandom_range(0, 999) == 0;
        end
        res = 1'b0;
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_backpressure();
        test_release();
        test_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
